ext_memory_responder: RTL and testbench

//  Responder (memory side) for the core's ext_* bus: serves instruction fetches and

---
 rtl/ext_memory_responder.sv | 154 +++++++++++++++
 tb/tb_ext_memory_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_memory_responder.sv
// ext_memory_responder
//   Memory-side responder for the core's ext_* bus. Serves instruction fetches and
//   data loads/stores from an internal word RAM after a fixed number of wait states,
//   and records out-of-window accesses and instruction-side writes in a sticky fault.
//
// Ports
//   clk               in   1   clock, all state on rising edge
//   reset             in   1   asynchronous, active-high reset
//   ext_valid         in   1   request pending; held high until ext_ready
//   ext_instruction   in   1   request is an instruction fetch
//   ext_ready         out  1   one-cycle completion pulse
//   ext_address       in   32  byte address; bits [1:0] ignored
//   ext_write_data    in   32  store data, lane i = bits [8i+7:8i]
//   ext_write_strobe  in   4   byte-lane write enables; 0 = read
//   ext_read_data     out  32  load/fetch data, non-zero only while ext_ready=1
//   access_fault      out  1   sticky fault flag
//   fault_address     out  32  ext_address of the first faulting request

module ext_memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_valid,
  input  logic        ext_instruction,
  output logic        ext_ready,
  input  logic [31:0] ext_address,
  input  logic [31:0] ext_write_data,
  input  logic [3:0]  ext_write_strobe,
  output logic [31:0] ext_read_data,
  output logic        access_fault,
  output logic [31:0] fault_address
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [31:0]           r_wdata;
  logic [3:0]            r_strobe;
  logic                  r_fault;
  logic [31:0]           r_address;
  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic                  r_access_fault;
  logic [31:0]           r_fault_address;

  logic [31:0]           r_mem [DEPTH];

  logic [31:0]           w_word;
  logic [ADDR_WIDTH-1:0] w_index;
  logic                  w_in_range;
  logic                  w_is_write;
  logic                  w_fault;
  logic                  w_do_write;

  // Word offset from the window base; addresses below BASE_ADDR wrap high and land out of range.
  assign w_word     = (ext_address - BASE_ADDR) >> 2;
  assign w_index    = w_word[ADDR_WIDTH-1:0];
  assign w_in_range = (w_word[31:ADDR_WIDTH] == '0);
  assign w_is_write = (ext_write_strobe != 4'b0000);
  assign w_fault    = !w_in_range || (ext_instruction && w_is_write);

  // Request FSM; read data is fetched on the edge entering RESP so it is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_index         <= '0;
      r_wdata         <= '0;
      r_strobe        <= '0;
      r_fault         <= 1'b0;
      r_address       <= '0;
      r_ready         <= 1'b0;
      r_rdata         <= '0;
      r_access_fault  <= 1'b0;
      r_fault_address <= '0;
    end else begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (ext_valid) begin
            r_index   <= w_index;
            r_wdata   <= ext_write_data;
            r_strobe  <= ext_write_strobe;
            r_fault   <= w_fault;
            r_address <= ext_address;
            r_cnt     <= WAIT_LOAD;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
              r_rdata <= (!w_fault && !w_is_write) ? r_mem[w_index] : '0;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Dropping ext_valid here is a protocol violation: abandon silently.
          if (!ext_valid) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_rdata <= (!r_fault && (r_strobe == 4'b0000)) ? r_mem[r_index] : '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (r_fault) begin
            r_access_fault <= 1'b1;
            if (!r_access_fault) begin
              r_fault_address <= r_address;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_do_write = (r_state == S_RESP) && !r_fault && (r_strobe != 4'b0000);

  // RAM write port: lanes commit on the edge that ends RESP; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_do_write && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (r_strobe[i]) begin
          r_mem[r_index][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign ext_ready     = r_ready;
  assign ext_read_data = r_rdata;
  assign access_fault  = r_access_fault;
  assign fault_address = r_fault_address;

endmodule

// File: tb/tb_ext_memory_responder.sv
// Bench for ext_memory_responder: three instances (0, 1 and 3 wait states) driven by
// directed sequences plus random traffic, checked against a word-map reference model.

module tb_ext_memory_responder;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic        valid  [3];
  logic        instr  [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [3:0]  strb   [3];
  logic        ready  [3];
  logic [31:0] rdata  [3];
  logic        fault  [3];
  logic [31:0] faddr  [3];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: sparse word map keyed by instance and word index, plus fault state.
  logic [31:0] mmem [int];
  bit          mflt   [3];
  logic [31:0] mfaddr [3];

  always #5 clk = ~clk;

  ext_memory_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .ext_valid(valid[0]), .ext_instruction(instr[0]),
    .ext_ready(ready[0]), .ext_address(addr[0]), .ext_write_data(wdata[0]),
    .ext_write_strobe(strb[0]), .ext_read_data(rdata[0]), .access_fault(fault[0]),
    .fault_address(faddr[0]));

  ext_memory_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .ext_valid(valid[1]), .ext_instruction(instr[1]),
    .ext_ready(ready[1]), .ext_address(addr[1]), .ext_write_data(wdata[1]),
    .ext_write_strobe(strb[1]), .ext_read_data(rdata[1]), .access_fault(fault[1]),
    .fault_address(faddr[1]));

  ext_memory_responder #(.ADDR_WIDTH(6), .BASE_ADDR(32'h0000_4000), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst[2]), .ext_valid(valid[2]), .ext_instruction(instr[2]),
    .ext_ready(ready[2]), .ext_address(addr[2]), .ext_write_data(wdata[2]),
    .ext_write_strobe(strb[2]), .ext_read_data(rdata[2]), .access_fault(fault[2]),
    .fault_address(faddr[2]));

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic int aw_of(input int k);
    return (k == 2) ? 6 : 12;
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? 32'h0000_4000 : 32'h0000_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_outputs_zero(input int k, input string tag);
    chk($sformatf("%s_ready%0d", tag, k), 32'(ready[k]), 32'h0);
    chk($sformatf("%s_rdata%0d", tag, k), rdata[k], 32'h0);
    chk($sformatf("%s_fault%0d", tag, k), 32'(fault[k]), 32'h0);
    chk($sformatf("%s_faddr%0d", tag, k), faddr[k], 32'h0);
  endtask

  // One bus transaction on instance k; keep leaves ext_valid high into the next IDLE.
  task automatic xfer(input int k, input bit ins, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input bit keep);
    logic [31:0] off;
    logic [31:0] exp_rd;
    longint      idx;
    bit          inr, flt, known, seen;
    int          key, lat;
    off    = a - base_of(k);
    idx    = longint'(off >> 2);
    inr    = idx < (longint'(1) << aw_of(k));
    flt    = !inr || (ins && st != 4'h0);
    key    = inr ? (k * (1 << 20) + int'(idx)) : -1;
    exp_rd = 32'h0;
    known  = 1'b1;
    if (!flt && st == 4'h0) begin
      if (mmem.exists(key)) exp_rd = mmem[key];
      else known = 1'b0;
    end
    @(negedge clk);
    valid[k] = 1'b1; instr[k] = ins; addr[k] = a; wdata[k] = wd; strb[k] = st;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ready[k]) seen = 1'b1;
      else chk($sformatf("rdata_quiet%0d", k), rdata[k], 32'h0);
      // Request inputs after acceptance must have no effect.
      instr[k] = 1'($urandom); addr[k] = $urandom; wdata[k] = $urandom; strb[k] = 4'($urandom);
    end
    chk($sformatf("latency%0d", k), 32'(lat), 32'(wait_of(k) + 1));
    if (seen && known) chk($sformatf("rdata%0d@%h", k, a), rdata[k], exp_rd);
    if (!keep) valid[k] = 1'b0;
    if (!flt && st != 4'h0) begin
      if (st == 4'hF) mmem[key] = wd;
      else if (mmem.exists(key))
        for (int i = 0; i < 4; i++)
          if (st[i]) mmem[key][8*i +: 8] = wd[8*i +: 8];
    end
    if (flt && !mflt[k]) begin
      mflt[k]   = 1'b1;
      mfaddr[k] = a;
    end
    @(posedge clk); #1;
    chk($sformatf("single_pulse%0d", k), 32'(ready[k]), 32'h0);
    chk($sformatf("fault%0d", k), 32'(fault[k]), 32'(mflt[k]));
    chk($sformatf("fault_addr%0d", k), faddr[k], mfaddr[k]);
  endtask

  task automatic rand_phase(input int k, input int n);
    logic [31:0] pool [8];
    logic [31:0] a;
    logic [3:0]  st;
    bit          ins, keep;
    int          sel;
    for (int i = 0; i < 8; i++) begin
      pool[i] = base_of(k) + (32'($urandom_range(0, (1 << aw_of(k)) - 1)) << 2);
      xfer(k, 1'b0, pool[i], $urandom, 4'hF, 1'b0);
    end
    for (int t = 0; t < n; t++) begin
      sel  = int'($urandom_range(0, 9));
      st   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      ins  = 1'b0;
      a    = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      keep = (t != n - 1) && ($urandom_range(0, 3) == 0);
      if (sel == 0)
        a = base_of(k) + (32'h1 << (aw_of(k) + 2)) + 32'($urandom_range(0, 20'hFFFFF));
      else if (sel == 1)
        a = base_of(k) - 32'($urandom_range(1, 4096));
      else if (sel == 2)
        ins = 1'b1;
      else if (sel == 3)
        ins = (st == 4'h0);
      xfer(k, ins, a, $urandom, st, keep);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; valid[k] = 1'b0; instr[k] = 1'b0;
      addr[k] = '0; wdata[k] = '0; strb[k] = '0;
      mflt[k] = 1'b0; mfaddr[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_outputs_zero(k, "reset");
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Full-word write then read back, one wait state.
    xfer(1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    xfer(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);

    // Single-lane merge into an existing word.
    xfer(1, 1'b0, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0);
    xfer(1, 1'b0, 32'h0000_0020, 32'h0000_AA00, 4'b0010, 1'b0);
    xfer(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0);

    // Just past the window, then wrapped below the base.
    xfer(1, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 1'b0);
    xfer(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0);

    // Instruction-side write is refused.
    xfer(0, 1'b0, 32'h0000_0000, 32'hA5A5_5A5A, 4'hF, 1'b0);
    xfer(0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 1'b0);
    xfer(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b0);

    // Zero wait states, valid held across three reads.
    xfer(0, 1'b0, 32'h0000_0100, 32'h0101_0101, 4'hF, 1'b0);
    xfer(0, 1'b0, 32'h0000_0104, 32'h0202_0202, 4'hF, 1'b0);
    xfer(0, 1'b0, 32'h0000_0108, 32'h0303_0303, 4'hF, 1'b0);
    xfer(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b1);
    xfer(0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b1);
    xfer(0, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 1'b0);

    // Reset in the middle of a write's wait states.
    xfer(2, 1'b0, 32'h0000_4008, 32'hCAFE_F00D, 4'hF, 1'b0);
    xfer(2, 1'b0, 32'h0000_3FFC, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    valid[2] = 1'b1; instr[2] = 1'b0; addr[2] = 32'h0000_4008;
    wdata[2] = 32'h1234_5678; strb[2] = 4'hF;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_pre_ready", 32'(ready[2]), 32'h0);
    end
    rst[2] = 1'b1;
    #1;
    chk_outputs_zero(2, "midreset");
    @(posedge clk); #1;
    chk_outputs_zero(2, "inreset");
    @(negedge clk);
    valid[2] = 1'b0; strb[2] = 4'h0; rst[2] = 1'b0;
    mflt[2] = 1'b0; mfaddr[2] = 32'h0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("rst_post_ready", 32'(ready[2]), 32'h0);
    end
    xfer(2, 1'b0, 32'h0000_4008, 32'h0, 4'h0, 1'b0);

    // ext_valid withdrawn during wait states: no pulse, no write, no fault.
    @(negedge clk);
    valid[2] = 1'b1; addr[2] = 32'h0000_4008; wdata[2] = 32'h5555_5555; strb[2] = 4'hF;
    @(posedge clk); #1;
    chk("drop_ready", 32'(ready[2]), 32'h0);
    @(negedge clk);
    valid[2] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("drop_quiet_ready", 32'(ready[2]), 32'h0);
      chk("drop_quiet_rdata", rdata[2], 32'h0);
    end
    xfer(2, 1'b0, 32'h0000_4008, 32'h0, 4'h0, 1'b0);

    rand_phase(1, 60);
    rand_phase(2, 40);
    rand_phase(0, 30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
